bh_run_ctrl: RTL



---
 rtl/bh_run_ctrl_if.sv | 18 +
 rtl/bh_run_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bh_run_ctrl_if.sv
// Load stream from a host or harness into bh_run_ctrl: program and tape bytes
// tagged by target, with the final beat flagged by s_last.
//
// Handshake: a beat transfers on the rising clock edge where s_valid && s_ready
// are both high. The master holds s_target/s_last/s_data stable while s_valid
// is high. s_ready never depends on s_valid. Cycles with s_valid low carry nothing.
interface bh_run_ctrl_if #(
  parameter int TAPE_DATA_WIDTH = 8
);
  logic                       s_valid;
  logic                       s_ready;
  logic                       s_target;
  logic                       s_last;
  logic [TAPE_DATA_WIDTH-1:0] s_data;

  modport master (output s_valid, s_target, s_last, s_data, input s_ready);
  modport slave  (input s_valid, s_target, s_last, s_data, output s_ready);
endinterface

// File: rtl/bh_run_ctrl.sv
// Run controller for the brainhack core: clears the tape, streams in program and
// tape contents, appends the end marker, then runs the core until end or budget.
module bh_run_ctrl #(
  parameter int                     PRG_ADDR_WIDTH  = 8,
  parameter int                     INSTR_WIDTH     = 4,
  parameter int                     TAPE_ADDR_WIDTH = 8,
  parameter int                     TAPE_DATA_WIDTH = 8,
  parameter int                     CYCLE_WIDTH     = 16,
  parameter logic [INSTR_WIDTH-1:0] END_OPCODE      = '1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [CYCLE_WIDTH-1:0]     max_cycles,
  bh_run_ctrl_if.slave               ld,
  output logic                       prg_we,
  output logic [PRG_ADDR_WIDTH-1:0]  prg_waddr,
  output logic [INSTR_WIDTH-1:0]     prg_wdata,
  output logic                       tape_we,
  output logic [TAPE_ADDR_WIDTH-1:0] tape_waddr,
  output logic [TAPE_DATA_WIDTH-1:0] tape_wdata,
  input  logic [INSTR_WIDTH-1:0]     core_instr,
  output logic                       core_rst_n,
  output logic                       core_run,
  output logic                       busy,
  output logic                       done,
  output logic                       timed_out,
  output logic                       load_error,
  output logic [CYCLE_WIDTH-1:0]     cycle_count,
  output logic [2:0]                 state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_TERM  = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [PRG_ADDR_WIDTH-1:0]  PRG_LAST  = '1;
  localparam logic [TAPE_ADDR_WIDTH-1:0] TAPE_LAST = '1;

  state_t                     state_q, state_d;
  logic [PRG_ADDR_WIDTH-1:0]  prg_cnt_q;
  // Extra MSB marks "tape full" so the counter never wraps back onto address 0.
  logic [TAPE_ADDR_WIDTH:0]   tape_cnt_q;
  logic [CYCLE_WIDTH-1:0]     max_q;
  logic [CYCLE_WIDTH-1:0]     cycle_q;
  logic                       done_q, timed_out_q, load_error_q;

  logic                       start_ok, accept, prg_full, tape_full, clear_last;
  logic                       hit_end, hit_budget;
  logic [CYCLE_WIDTH:0]       cycle_next;

  assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept     = ld.s_valid && (state_q == ST_LOAD);
  // The top program address is reserved for the end marker.
  assign prg_full   = (prg_cnt_q == PRG_LAST);
  assign tape_full  = tape_cnt_q[TAPE_ADDR_WIDTH];
  assign clear_last = (tape_cnt_q[TAPE_ADDR_WIDTH-1:0] == TAPE_LAST);
  assign hit_end    = (core_instr == END_OPCODE);
  // One bit wider so a saturated counter can never alias onto the budget.
  assign cycle_next = {1'b0, cycle_q} + 1'b1;
  assign hit_budget = (max_q != '0) && (cycle_next == {1'b0, max_q});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_CLEAR;
      ST_CLEAR:         if (clear_last) state_d = ST_LOAD;
      ST_LOAD:          if (accept && ld.s_last) state_d = ST_TERM;
      ST_TERM:          state_d = load_error_q ? ST_DONE : ST_RUN;
      ST_RUN:           if (hit_end || hit_budget) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prg_cnt_q    <= '0;
      tape_cnt_q   <= '0;
      max_q        <= '0;
      cycle_q      <= '0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      if (start_ok) begin
        prg_cnt_q    <= '0;
        tape_cnt_q   <= '0;
        max_q        <= max_cycles;
        cycle_q      <= '0;
        done_q       <= 1'b0;
        timed_out_q  <= 1'b0;
        load_error_q <= 1'b0;
      end
      case (state_q)
        // The tape counter doubles as the clear address and restarts for loading.
        ST_CLEAR: tape_cnt_q <= clear_last ? '0 : tape_cnt_q + 1'b1;
        ST_LOAD: begin
          if (accept) begin
            if (!ld.s_target) begin
              if (prg_full) load_error_q <= 1'b1;
              else          prg_cnt_q    <= prg_cnt_q + 1'b1;
            end else begin
              if (tape_full) load_error_q <= 1'b1;
              else           tape_cnt_q   <= tape_cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (cycle_q != '1) cycle_q <= cycle_q + 1'b1;
          if (hit_end)         done_q      <= 1'b1;
          else if (hit_budget) timed_out_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld.s_ready = 1'b0;
    prg_we     = 1'b0;
    prg_waddr  = '0;
    prg_wdata  = '0;
    tape_we    = 1'b0;
    tape_waddr = '0;
    tape_wdata = '0;
    core_rst_n = 1'b0;
    core_run   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy       = 1'b1;
        tape_we    = 1'b1;
        tape_waddr = tape_cnt_q[TAPE_ADDR_WIDTH-1:0];
      end
      ST_LOAD: begin
        busy       = 1'b1;
        ld.s_ready = 1'b1;
        prg_waddr  = prg_cnt_q;
        prg_wdata  = ld.s_data[INSTR_WIDTH-1:0];
        prg_we     = accept && !ld.s_target && !prg_full;
        tape_waddr = tape_cnt_q[TAPE_ADDR_WIDTH-1:0];
        tape_wdata = ld.s_data;
        tape_we    = accept && ld.s_target && !tape_full;
      end
      ST_TERM: begin
        busy      = 1'b1;
        prg_we    = 1'b1;
        prg_waddr = prg_cnt_q;
        prg_wdata = END_OPCODE;
      end
      ST_RUN: begin
        busy       = 1'b1;
        core_rst_n = 1'b1;
        core_run   = 1'b1;
      end
      // Core held out of reset but frozen so its state can be inspected.
      ST_DONE: core_rst_n = 1'b1;
      default: ;
    endcase
  end

  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign load_error  = load_error_q;
  assign cycle_count = cycle_q;
  assign state_dbg   = state_q;

endmodule
